// File: rtl/ff_pkg.sv
// Shared constants and helpers for the ff_pipe register pipeline.
package ff_pkg;

    localparam int MAX_DEPTH = 16;

    // Bits needed to hold a stage count in the range 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ff_stage.sv
// One pipeline stage: a valid bit and a data word with enable, flush and sync reset.
module ff_stage #(
    parameter int                WIDTH        = 8,
    parameter logic [WIDTH-1:0]  RST_VAL      = '0,
    parameter bit                ZERO_INVALID = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= RST_VAL;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_data  <= RST_VAL;
        end else if (en) begin
            out_valid <= in_valid;
            // Substituting RST_VAL keeps unknown data on invalid cycles out of the pipe.
            out_data  <= (ZERO_INVALID && !in_valid) ? RST_VAL : in_data;
        end
    end

endmodule

// File: rtl/ff_pipe.sv
// DEPTH-stage valid/data register pipeline with stall, flush and occupancy count.
// in_valid qualifies in_data; there is no ready, en is the only way to stall the pipe.
module ff_pipe
    import ff_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter int               DEPTH        = 4,
    parameter logic [WIDTH-1:0] RST_VAL      = '0,
    parameter bit               ZERO_INVALID = 1'b0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [cnt_w(DEPTH)-1:0]   count
);

    localparam int CW = cnt_w(DEPTH);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            ff_stage #(
                .WIDTH        (WIDTH),
                .RST_VAL      (RST_VAL),
                .ZERO_INVALID (ZERO_INVALID)
            ) u_stage (
                .clk       (clk),
                .reset     (reset),
                .en        (en),
                .flush     (flush),
                .in_valid  (in_valid),
                .in_data   (in_data),
                .out_valid (v[gi]),
                .out_data  (d[gi])
            );
        end else begin : g_body
            // Upstream data is already cleaned when invalid, so no substitution here.
            ff_stage #(
                .WIDTH        (WIDTH),
                .RST_VAL      (RST_VAL),
                .ZERO_INVALID (1'b0)
            ) u_stage (
                .clk       (clk),
                .reset     (reset),
                .en        (en),
                .flush     (flush),
                .in_valid  (v[gi-1]),
                .in_data   (d[gi-1]),
                .out_valid (v[gi]),
                .out_data  (d[gi])
            );
        end
    end

    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

    // Incremental popcount: one word enters, one leaves, or both (no change).
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (en) begin
            case ({in_valid, v[DEPTH-1]})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_ff_pipe.sv
// Directed self-checking bench for ff_pipe: a DEPTH=3 pipe and a DEPTH=1 ZERO_INVALID pipe.
module tb_ff_pipe;
    import ff_pkg::*;

    localparam int AW = cnt_w(3);
    localparam int BW = cnt_w(1);

    logic          clk = 1'b0;
    logic          reset;

    logic          a_en, a_flush, a_in_valid, a_out_valid;
    logic [7:0]    a_in_data, a_out_data;
    logic [AW-1:0] a_count;

    logic          b_en, b_flush, b_in_valid, b_out_valid;
    logic [7:0]    b_in_data, b_out_data;
    logic [BW-1:0] b_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ff_pipe #(.WIDTH(8), .DEPTH(3), .RST_VAL(8'h00), .ZERO_INVALID(1'b0)) u_a (
        .clk(clk), .reset(reset), .en(a_en), .flush(a_flush),
        .in_valid(a_in_valid), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_data(a_out_data), .count(a_count)
    );

    ff_pipe #(.WIDTH(8), .DEPTH(1), .RST_VAL(8'h5a), .ZERO_INVALID(1'b1)) u_b (
        .clk(clk), .reset(reset), .en(b_en), .flush(b_flush),
        .in_valid(b_in_valid), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_data(b_out_data), .count(b_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive pipe A for one edge, then sample 1 time unit after the edge.
    task automatic step_a(input logic en, input logic flush, input logic vld, input logic [7:0] data);
        a_en = en; a_flush = flush; a_in_valid = vld; a_in_data = data;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic ov, input logic [7:0] od, input int cnt);
        chk({tag, ".valid"}, 32'(a_out_valid), 32'(ov));
        chk({tag, ".data"},  32'(a_out_data),  32'(od));
        chk({tag, ".count"}, 32'(a_count),     32'(cnt));
    endtask

    initial begin
        reset = 1'b0;
        a_en = 1'b1; a_flush = 1'b0; a_in_valid = 1'b1; a_in_data = 8'hab;
        b_en = 1'b1; b_flush = 1'b0; b_in_valid = 1'b1; b_in_data = 8'hab;

        // Reset held two edges with live traffic on the inputs
        step_a(1'b1, 1'b0, 1'b1, 8'hab);
        chk_a("rst1", 1'b0, 8'h00, 0);
        step_a(1'b1, 1'b0, 1'b1, 8'hab);
        chk_a("rst2", 1'b0, 8'h00, 0);
        chk("b_rst.data",  32'(b_out_data),  32'h5a);
        chk("b_rst.valid", 32'(b_out_valid), 32'h0);
        b_en = 1'b0;
        reset = 1'b1;

        // Streaming: first word reaches the output on the third edge
        step_a(1'b1, 1'b0, 1'b1, 8'hab); chk_a("s1", 1'b0, 8'h00, 1);
        step_a(1'b1, 1'b0, 1'b1, 8'hbc); chk_a("s2", 1'b0, 8'h00, 2);
        step_a(1'b1, 1'b0, 1'b1, 8'hcd); chk_a("s3", 1'b1, 8'hab, 3);
        step_a(1'b1, 1'b0, 1'b1, 8'hde); chk_a("s4", 1'b1, 8'hbc, 3);
        step_a(1'b1, 1'b0, 1'b1, 8'hef); chk_a("s5", 1'b1, 8'hcd, 3);
        step_a(1'b1, 1'b0, 1'b0, 8'h00); chk_a("d1", 1'b1, 8'hde, 2);
        step_a(1'b1, 1'b0, 1'b0, 8'h00); chk_a("d2", 1'b1, 8'hef, 1);
        step_a(1'b1, 1'b0, 1'b0, 8'h00); chk_a("d3", 1'b0, 8'h00, 0);

        // Stall: en low holds everything and ignores the inputs
        step_a(1'b1, 1'b0, 1'b1, 8'hab); chk_a("st0", 1'b0, 8'h00, 1);
        for (int i = 0; i < 4; i++) begin
            step_a(1'b0, 1'b0, 1'b1, 8'h11);
            chk_a($sformatf("hold%0d", i), 1'b0, 8'h00, 1);
        end
        step_a(1'b1, 1'b0, 1'b0, 8'h00); chk_a("res1", 1'b0, 8'h00, 1);
        step_a(1'b1, 1'b0, 1'b0, 8'h00); chk_a("res2", 1'b1, 8'hab, 1);
        step_a(1'b1, 1'b0, 1'b0, 8'h00); chk_a("res3", 1'b0, 8'h00, 0);

        // Flush beats en and drops the word presented on that edge
        step_a(1'b1, 1'b0, 1'b1, 8'h11);
        step_a(1'b1, 1'b0, 1'b1, 8'h22);
        step_a(1'b1, 1'b0, 1'b1, 8'h33); chk_a("full", 1'b1, 8'h11, 3);
        step_a(1'b1, 1'b1, 1'b1, 8'hee); chk_a("fl", 1'b0, 8'h00, 0);
        for (int i = 0; i < 3; i++) begin
            step_a(1'b1, 1'b0, 1'b0, 8'h00);
            chk_a($sformatf("fl_after%0d", i), 1'b0, 8'h00, 0);
        end

        // Flush with en low still clears
        step_a(1'b1, 1'b0, 1'b1, 8'h77);
        step_a(1'b1, 1'b0, 1'b1, 8'h78); chk_a("pre_fl2", 1'b0, 8'h00, 2);
        step_a(1'b0, 1'b1, 1'b1, 8'h79); chk_a("fl_noen", 1'b0, 8'h00, 0);

        // Reset mid-stream discards in-flight words
        step_a(1'b1, 1'b0, 1'b1, 8'h44);
        step_a(1'b1, 1'b0, 1'b1, 8'h55);
        step_a(1'b1, 1'b0, 1'b1, 8'h66); chk_a("full2", 1'b1, 8'h44, 3);
        reset = 1'b0;
        step_a(1'b1, 1'b0, 1'b1, 8'h99); chk_a("mrst", 1'b0, 8'h00, 0);
        reset = 1'b1;
        step_a(1'b1, 1'b0, 1'b1, 8'hbc); chk_a("post1", 1'b0, 8'h00, 1);
        step_a(1'b1, 1'b0, 1'b0, 8'h00); chk_a("post2", 1'b0, 8'h00, 1);
        step_a(1'b1, 1'b0, 1'b0, 8'h00); chk_a("post3", 1'b1, 8'hbc, 1);
        a_en = 1'b0;

        // DEPTH=1, ZERO_INVALID=1, RST_VAL=5a
        b_en = 1'b1; b_in_valid = 1'b0; b_in_data = 8'hff;
        @(posedge clk); #1;
        chk("b_inv.data",  32'(b_out_data),  32'h5a);
        chk("b_inv.valid", 32'(b_out_valid), 32'h0);
        chk("b_inv.count", 32'(b_count),     32'h0);
        b_in_valid = 1'b1; b_in_data = 8'hff;
        @(posedge clk); #1;
        chk("b_v.data",  32'(b_out_data),  32'hff);
        chk("b_v.valid", 32'(b_out_valid), 32'h1);
        chk("b_v.count", 32'(b_count),     32'h1);
        b_in_data = 8'h3c;
        @(posedge clk); #1;
        chk("b_both.data",  32'(b_out_data), 32'h3c);
        chk("b_both.count", 32'(b_count),    32'h1);
        b_in_valid = 1'b0; b_in_data = 8'hc3;
        @(posedge clk); #1;
        chk("b_out.data",  32'(b_out_data), 32'h5a);
        chk("b_out.count", 32'(b_count),    32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
